reset_button_ctrl: RTL

RESET_BUTTON_CTRL -- requirements
Module: reset_button_ctrl

---
 rtl/reset_button_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/reset_button_ctrl.sv
// Debounced pushbutton front end plus stretched system-reset generator; RESET_BUTTON_LONG_PRESS_EN adds long-press pulses.
// Latency: raw edge to btn_state is 2+DB_CYCLES cycles, trigger to sys_reset is one edge; no backpressure (pulses are fire-and-forget).
module reset_button_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int DB_CYCLES     = 20000,
    parameter int RST_STRETCH   = 1024,
    parameter int RST_CH        = 0,
    parameter int ACTIVE_LOW_IN = 1,
    parameter int LONG_CYCLES   = 2000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic              por_req,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] long_press,
    output logic              sys_reset
);

    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam int STW = $clog2(RST_STRETCH) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [STW-1:0] ST_LAST = STW'(RST_STRETCH - 1);
    localparam logic [NUM_CH-1:0] IDLE_RAW = (ACTIVE_LOW_IN != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_t;

    logic [NUM_CH-1:0]          btn_meta_q;
    logic [NUM_CH-1:0]          btn_sync_q;
    logic                       por_meta_q;
    logic                       por_sync_q;
    logic [NUM_CH-1:0]          btn_lvl;

    logic [NUM_CH-1:0][DBW-1:0] db_cnt_q;
    logic [NUM_CH-1:0][DBW-1:0] db_cnt_d;
    logic [NUM_CH-1:0]          state_q;
    logic [NUM_CH-1:0]          state_d;
    logic [NUM_CH-1:0]          press_q;
    logic [NUM_CH-1:0]          press_d;
    logic [NUM_CH-1:0]          release_q;
    logic [NUM_CH-1:0]          release_d;

    rst_state_t                 rst_state_q;
    logic [STW-1:0]             st_cnt_q;
    logic                       sys_reset_q;
    logic                       trigger;

    // Synchronizers reset to the idle (not pressed / no request) level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_meta_q <= IDLE_RAW;
            btn_sync_q <= IDLE_RAW;
            por_meta_q <= 1'b0;
            por_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_in;
            btn_sync_q <= btn_meta_q;
            por_meta_q <= por_req;
            por_sync_q <= por_meta_q;
        end
    end

    assign btn_lvl = (ACTIVE_LOW_IN != 0) ? ~btn_sync_q : btn_sync_q;

    // Any return to equality restarts the window, so bounces never reach DB_LAST.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_d[i]  = db_cnt_q[i];
            state_d[i]   = state_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            if (btn_lvl[i] == state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]  = '0;
                state_d[i]   = ~state_q[i];
                press_d[i]   = ~state_q[i];
                release_d[i] = state_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_cnt_q  <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_state   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef RESET_BUTTON_LONG_PRESS_EN
    localparam int LPW = $clog2(LONG_CYCLES) + 1;
    localparam logic [LPW-1:0] LONG_LAST = LPW'(LONG_CYCLES - 1);
    localparam logic [LPW-1:0] LONG_SAT  = LPW'(LONG_CYCLES);

    logic [NUM_CH-1:0][LPW-1:0] hold_q;
    logic [NUM_CH-1:0][LPW-1:0] hold_d;
    logic [NUM_CH-1:0]          long_q;
    logic [NUM_CH-1:0]          long_d;

    // Hold counter parks at LONG_SAT so each press yields a single pulse.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hold_d[i] = hold_q[i];
            long_d[i] = 1'b0;
            if (!state_q[i]) begin
                hold_d[i] = '0;
            end else begin
                long_d[i] = (hold_q[i] == LONG_LAST);
                if (hold_q[i] != LONG_SAT) begin
                    hold_d[i] = hold_q[i] + LPW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = '0;
`endif

    assign trigger = por_sync_q | state_q[RST_CH];

    // Any trigger in HOLD restarts the stretch from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_state_q <= HOLD;
            st_cnt_q    <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            case (rst_state_q)
                HOLD: begin
                    sys_reset_q <= 1'b1;
                    if (trigger) begin
                        st_cnt_q <= '0;
                    end else if (st_cnt_q == ST_LAST) begin
                        rst_state_q <= RUN;
                        st_cnt_q    <= '0;
                        sys_reset_q <= 1'b0;
                    end else begin
                        st_cnt_q <= st_cnt_q + STW'(1);
                    end
                end
                RUN: begin
                    sys_reset_q <= 1'b0;
                    if (trigger) begin
                        rst_state_q <= HOLD;
                        st_cnt_q    <= '0;
                        sys_reset_q <= 1'b1;
                    end
                end
                default: begin
                    rst_state_q <= HOLD;
                    st_cnt_q    <= '0;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign sys_reset = sys_reset_q;

endmodule
